axis_pixel_packer: RTL and testbench

- Downstream stage of the bicubic upsampling IP. Consumes its 24-bit RGB output pixel stream and packs PIX_PER_BEAT pixels per AXI-Stream beat, padding each pixel to 32 bits for the DMA write path.
- Regenerates line framing (tlast) and frame framing (tuser) from DST_IMG_WIDTH/DST_IMG_HEIGHT counters.
- Flags upstream tlast mismatches and pulses frame completion.

---
 rtl/axis_pixel_packer.sv | 159 +++++++++++++++
 tb/tb_axis_pixel_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pixel_packer.sv
// Packs 24-bit RGB pixels into 32-bit lanes, PIX_PER_BEAT per AXI-Stream beat,
// regenerating line/frame framing from local counters behind a 2-entry output FIFO.
module axis_pixel_packer #(
  parameter  int IN_DATA_WIDTH  = 24,
  parameter  int PIX_PER_BEAT   = 2,
  parameter  int DST_IMG_WIDTH  = 4096,
  parameter  int DST_IMG_HEIGHT = 2160,
  localparam int OUT_DATA_WIDTH = 32 * PIX_PER_BEAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [IN_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [OUT_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [OUT_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic                        frame_done,
  output logic                        err_tlast
);

  localparam int COL_W  = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
  localparam int ROW_W  = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam int SLOT_W = (PIX_PER_BEAT   > 1) ? $clog2(PIX_PER_BEAT)   : 1;
  localparam int KEEP_W = OUT_DATA_WIDTH / 8;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              rstDly_q;

  logic [OUT_DATA_WIDTH-1:0] beatData_q, beatData_d, asmData;
  logic [KEEP_W-1:0]         beatKeep_q, beatKeep_d, asmKeep;
  logic                      beatLast_q, beatLast_d, asmLast;
  logic                      beatUser_q, beatUser_d, asmUser;
  logic                      beatEnd_q, beatEnd_d, asmEnd;

  logic [OUT_DATA_WIDTH-1:0] memData_q [2];
  logic [KEEP_W-1:0]         memKeep_q [2];
  logic                      memLast_q [2];
  logic                      memUser_q [2];
  logic                      memEnd_q  [2];
  logic                      wrPtr_q, rdPtr_q;
  logic [1:0]                count_q;
  logic                      frameDone_q, errTlast_q;

  logic accept, colLast, rowLast, slotLast, push, pop;
  logic [31:0] lanePix;

  assign s_axis_tready = !rstDly_q && (count_q != 2'd2);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign colLast       = (col_q == COL_W'(DST_IMG_WIDTH - 1));
  assign rowLast       = (row_q == ROW_W'(DST_IMG_HEIGHT - 1));
  assign slotLast      = (slot_q == SLOT_W'(PIX_PER_BEAT - 1));
  assign push          = accept && (slotLast || colLast);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign lanePix       = {{(32 - IN_DATA_WIDTH){1'b0}}, s_axis_tdata};

  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = memData_q[rdPtr_q];
  assign m_axis_tkeep  = memKeep_q[rdPtr_q];
  assign m_axis_tlast  = memLast_q[rdPtr_q];
  assign m_axis_tuser  = memUser_q[rdPtr_q];
  assign frame_done    = frameDone_q;
  assign err_tlast     = errTlast_q;

  // Merge the incoming pixel into the partial beat; a completed beat is pushed
  // as assembled and the accumulator restarts empty at lane 0.
  always_comb begin
    asmData = beatData_q;
    asmKeep = beatKeep_q;
    asmLast = beatLast_q;
    asmUser = beatUser_q;
    asmEnd  = beatEnd_q;
    col_d   = col_q;
    row_d   = row_q;
    slot_d  = slot_q;
    if (accept) begin
      for (int l = 0; l < PIX_PER_BEAT; l++) begin
        if (slot_q == SLOT_W'(l)) begin
          asmData[32*l +: 32] = lanePix;
          asmKeep[4*l +: 4]   = 4'hF;
        end
      end
      if (colLast) asmLast = 1'b1;
      if (colLast && rowLast) asmEnd = 1'b1;
      if (col_q == '0 && row_q == '0) asmUser = 1'b1;
      if (colLast) begin
        col_d = '0;
        row_d = rowLast ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      slot_d = (slotLast || colLast) ? '0 : slot_q + SLOT_W'(1);
    end
    beatData_d = push ? '0 : asmData;
    beatKeep_d = push ? '0 : asmKeep;
    beatLast_d = push ? 1'b0 : asmLast;
    beatUser_d = push ? 1'b0 : asmUser;
    beatEnd_d  = push ? 1'b0 : asmEnd;
  end

  always_ff @(posedge clk) begin
    rstDly_q <= rst;
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      slot_q      <= '0;
      beatData_q  <= '0;
      beatKeep_q  <= '0;
      beatLast_q  <= 1'b0;
      beatUser_q  <= 1'b0;
      beatEnd_q   <= 1'b0;
      wrPtr_q     <= 1'b0;
      rdPtr_q     <= 1'b0;
      count_q     <= 2'd0;
      frameDone_q <= 1'b0;
      errTlast_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        memData_q[i] <= '0;
        memKeep_q[i] <= '0;
        memLast_q[i] <= 1'b0;
        memUser_q[i] <= 1'b0;
        memEnd_q[i]  <= 1'b0;
      end
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      slot_q     <= slot_d;
      beatData_q <= beatData_d;
      beatKeep_q <= beatKeep_d;
      beatLast_q <= beatLast_d;
      beatUser_q <= beatUser_d;
      beatEnd_q  <= beatEnd_d;
      if (push) begin
        memData_q[wrPtr_q] <= asmData;
        memKeep_q[wrPtr_q] <= asmKeep;
        memLast_q[wrPtr_q] <= asmLast;
        memUser_q[wrPtr_q] <= asmUser;
        memEnd_q[wrPtr_q]  <= asmEnd;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      frameDone_q <= pop && memEnd_q[rdPtr_q];
      // Upstream tlast is only audited; framing always follows the local column counter.
      if (accept && (s_axis_tlast != colLast)) errTlast_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Directed bench for axis_pixel_packer at W=5, H=2, two pixels per beat:
// a hand-computed beat table plus multi-cycle sequences checked against a line-based packing model.
module tb_axis_pixel_packer;

  localparam int W = 5;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        frame_done;
  logic        err_tlast;

  axis_pixel_packer #(
    .PIX_PER_BEAT  (2),
    .DST_IMG_WIDTH (W),
    .DST_IMG_HEIGHT(H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .frame_done   (frame_done),
    .err_tlast    (err_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    logic [23:0] pix0;
    logic [23:0] pix1;
    int          nPix;
    logic [63:0] expData;
    logic [7:0]  expKeep;
    logic        expLast;
    logic        expUser;
  } vec_t;

  beat_t got[$];
  beat_t expQ[$];
  vec_t  vec[6];
  int    testCount = 0;
  int    failCount = 0;
  int    cycle = 0;
  int    fdCount = 0;
  int    fdCycle = -1;
  int    lastPopCycle = -1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One clock: drive inputs, note handshakes just before the edge, sample #1 after it.
  task automatic applyStimulus(input bit vld, input logic [23:0] pix, input bit tl, input bit rdy,
                               output bit acc);
    beat_t b;
    bit    popped;
    s_axis_tvalid = vld;
    s_axis_tdata  = pix;
    s_axis_tlast  = tl;
    m_axis_tready = rdy;
    #1;
    acc    = vld && s_axis_tready;
    popped = 1'b0;
    if (m_axis_tvalid && rdy) begin
      b.data = m_axis_tdata;
      b.keep = m_axis_tkeep;
      b.last = m_axis_tlast;
      b.user = m_axis_tuser;
      got.push_back(b);
      popped = 1'b1;
    end
    @(posedge clk);
    #1;
    cycle++;
    if (popped) lastPopCycle = cycle;
    if (frame_done === 1'b1) begin
      fdCount++;
      fdCycle = cycle;
    end
  endtask

  task automatic sendOne(input logic [23:0] pix, input bit tl, input bit rdy);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      applyStimulus(1'b1, pix, tl, rdy, acc);
      guard++;
    end
    if (!acc) checkOutput("send_one_timeout", 64'(guard), 64'(0));
  endtask

  task automatic sendPixels(input int base, input int startK, input int n, input int vPct, input int rPct);
    bit acc;
    bit vld;
    bit rdy;
    int k;
    int guard;
    k     = startK;
    guard = 0;
    while (k < n && guard < 5000) begin
      vld = ($urandom_range(99) < vPct);
      rdy = ($urandom_range(99) < rPct);
      applyStimulus(vld, 24'(base + k), ((k % W) == W - 1), rdy, acc);
      if (acc) k++;
      guard++;
    end
    if (k < n) checkOutput("send_pixels_timeout", 64'(k), 64'(n));
  endtask

  task automatic drain();
    bit acc;
    int guard;
    guard = 0;
    while (m_axis_tvalid && guard < 50) begin
      applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, acc);
      guard++;
    end
    if (m_axis_tvalid) checkOutput("drain_timeout", 64'(1), 64'(0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, acc);
  endtask

  // Golden packing built line by line: pixel pairs, short final beat on odd widths.
  task automatic genExpected(input int base, input int n);
    beat_t b;
    expQ.delete();
    for (int line = 0; line < n / W; line++) begin
      for (int j = 0; j < W; j += 2) begin
        b.data = '0;
        b.keep = '0;
        for (int l = 0; l < 2; l++) begin
          if (j + l < W) begin
            b.data[32*l +: 24] = 24'(base + line * W + j + l);
            b.keep[4*l +: 4]   = 4'hF;
          end
        end
        b.last = (j + 2 >= W);
        b.user = ((line % H) == 0) && (j == 0);
        expQ.push_back(b);
      end
    end
  endtask

  task automatic compareBeats(input string name);
    checkOutput($sformatf("%s_beat_count", name), 64'(got.size()), 64'(expQ.size()));
    for (int i = 0; i < got.size() && i < expQ.size(); i++) begin
      checkOutput($sformatf("%s_data[%0d]", name, i), got[i].data, expQ[i].data);
      checkOutput($sformatf("%s_keep[%0d]", name, i), 64'(got[i].keep), 64'(expQ[i].keep));
      checkOutput($sformatf("%s_last_user[%0d]", name, i), 64'({got[i].last, got[i].user}),
                  64'({expQ[i].last, expQ[i].user}));
    end
  endtask

  initial begin
    bit acc;
    int k;

    vec[0] = '{24'h000001, 24'h000002, 2, 64'h00000002_00000001, 8'hFF, 1'b0, 1'b1};
    vec[1] = '{24'h000003, 24'h000004, 2, 64'h00000004_00000003, 8'hFF, 1'b0, 1'b0};
    vec[2] = '{24'h000005, 24'h000000, 1, 64'h00000000_00000005, 8'h0F, 1'b1, 1'b0};
    vec[3] = '{24'h000006, 24'h000007, 2, 64'h00000007_00000006, 8'hFF, 1'b0, 1'b0};
    vec[4] = '{24'h000008, 24'h000009, 2, 64'h00000009_00000008, 8'hFF, 1'b0, 1'b0};
    vec[5] = '{24'h00000A, 24'h000000, 1, 64'h00000000_0000000A, 8'h0F, 1'b1, 1'b0};

    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, acc);
    checkOutput("rst_s_tready", 64'(s_axis_tready), 64'(0));
    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("rst_m_tdata", m_axis_tdata, 64'h0);
    checkOutput("rst_m_tkeep", 64'(m_axis_tkeep), 64'(0));
    checkOutput("rst_flags", 64'({m_axis_tlast, m_axis_tuser, frame_done, err_tlast}), 64'(0));
    rst = 1'b0;
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b1, acc);
    checkOutput("post_rst_s_tready", 64'(s_axis_tready), 64'(1));

    // Hand-computed beat table, one frame at full rate
    got.delete();
    fdCount = 0;
    for (int i = 0; i < 6; i++) begin
      if (vec[i].nPix == 2) begin
        sendOne(vec[i].pix0, 1'b0, 1'b1);
        sendOne(vec[i].pix1, vec[i].expLast, 1'b1);
      end else begin
        sendOne(vec[i].pix0, vec[i].expLast, 1'b1);
      end
      if (i == 0) begin
        checkOutput("latency_tvalid", 64'(m_axis_tvalid), 64'(1));
        checkOutput("latency_tdata", m_axis_tdata, vec[0].expData);
      end
    end
    drain();
    checkOutput("table_beat_count", 64'(got.size()), 64'(6));
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checkOutput($sformatf("table_data[%0d]", i), got[i].data, vec[i].expData);
      checkOutput($sformatf("table_keep[%0d]", i), 64'(got[i].keep), 64'(vec[i].expKeep));
      checkOutput($sformatf("table_last[%0d]", i), 64'(got[i].last), 64'(vec[i].expLast));
      checkOutput($sformatf("table_user[%0d]", i), 64'(got[i].user), 64'(vec[i].expUser));
    end
    checkOutput("table_frame_done_count", 64'(fdCount), 64'(1));
    checkOutput("table_frame_done_cycle", 64'(fdCycle), 64'(lastPopCycle));

    // Backpressure: FIFO fills after 4 pixels, head must hold
    got.delete();
    k = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 24'(32'h100 + k), ((k % W) == W - 1), 1'b0, acc);
      if (acc) k++;
      if (m_axis_tvalid) checkOutput("bp_head_stable", m_axis_tdata, 64'h00000101_00000100);
    end
    checkOutput("bp_accepted", 64'(k), 64'(4));
    checkOutput("bp_s_tready_low", 64'(s_axis_tready), 64'(0));
    sendPixels(32'h100, k, 10, 100, 100);
    drain();
    genExpected(32'h100, 10);
    compareBeats("bp");

    // Random valid/ready over three frames
    got.delete();
    fdCount = 0;
    sendPixels(32'h200, 0, 3 * W * H, 70, 60);
    drain();
    genExpected(32'h200, 3 * W * H);
    compareBeats("rand");
    checkOutput("rand_frame_done_count", 64'(fdCount), 64'(3));

    // Wrong upstream tlast on pixel 3: sticky error, framing untouched
    got.delete();
    checkOutput("err_clear_before", 64'(err_tlast), 64'(0));
    for (int j = 0; j < 10; j++) begin
      sendOne(24'(32'h300 + j), (j == 2) || (j == 9), 1'b1);
      if (j == 1) checkOutput("err_before_bad_tlast", 64'(err_tlast), 64'(0));
      if (j == 2) checkOutput("err_after_bad_tlast", 64'(err_tlast), 64'(1));
    end
    drain();
    checkOutput("err_sticky", 64'(err_tlast), 64'(1));
    genExpected(32'h300, 10);
    compareBeats("err");

    // Reset mid-frame: queued and partial beats must vanish
    got.delete();
    for (int j = 0; j < 3; j++) sendOne(24'(32'h400 + j), 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, acc);
    rst = 1'b0;
    checkOutput("midrst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("midrst_err_cleared", 64'(err_tlast), 64'(0));
    sendPixels(32'h500, 0, 10, 100, 100);
    drain();
    genExpected(32'h500, 10);
    compareBeats("midrst");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
